// File: rtl/vram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vram_arbiter                                                  |
// | Purpose  : Time-slot arbiter sharing one single-port 16 KB video RAM     |
// |            between the video adapter (slot 0, data back in slot 1) and   |
// |            the Z80 CPU (slots 2 and 3).                                  |
// | Option   : VRAM_WBUF_EN - when defined, CPU writes are posted into a     |
// |            WBUF_DEPTH-entry FIFO; otherwise writes go through the same   |
// |            three-state access FSM as reads.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vram_arbiter #(
   parameter int WBUF_DEPTH = 4,
   parameter int WBUF_AW    = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [13:0] vid_addr,
   output logic [7:0]  vid_data,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [13:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_wait,
   output logic [13:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_DONE = 2'd2
   } state_t;

   logic [1:0] ph_q, ph_d;
   state_t     state_q, state_d;
   logic [7:0] vid_data_q, vid_data_d;
   logic [7:0] cpu_rdata_q, cpu_rdata_d;
   // Remembers whether the access in flight is a write, so DONE never
   // overwrites the read-data register with a write cycle's RAM output.
   logic       op_we_q, op_we_d;
   logic       cpu_slot;

   assign cpu_slot = ph_q[1];

`ifdef VRAM_WBUF_EN
   localparam logic [WBUF_AW:0] DEPTH_C = (WBUF_AW+1)'(WBUF_DEPTH);

   logic [13:0]        fifo_addr_q [WBUF_DEPTH];
   logic [7:0]         fifo_data_q [WBUF_DEPTH];
   logic [WBUF_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [WBUF_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [WBUF_AW:0]   count_q, count_d;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;

   // Full is taken from the registered count so a same-cycle pop never
   // opens room for a push.
   assign fifo_full  = (count_q == DEPTH_C);
   assign fifo_empty = (count_q == '0);
   assign push       = cpu_req & cpu_we & ~fifo_full;

   // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
   always_comb begin
      wr_ptr_d = push ? (wr_ptr_q + WBUF_AW'(1)) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + WBUF_AW'(1)) : rd_ptr_q;
      count_d  = count_q + (WBUF_AW+1)'(push) - (WBUF_AW+1)'(pop);
   end

   // FIFO storage; contents need no reset because count gates every read.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= cpu_addr;
         fifo_data_q[wr_ptr_q] <= cpu_wdata;
      end
   end

   // FIFO control registers; a reset discards any buffered writes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
`endif

   // Slot counter and the video byte captured in slot 1.
   always_comb begin
      ph_d       = ph_q + 2'd1;
      vid_data_d = (ph_q == 2'd1) ? mem_rdata : vid_data_q;
   end

   // Slot arbitration, RAM port muxing and access FSM next state.
   always_comb begin
      mem_addr    = vid_addr;
      mem_we      = 1'b0;
      mem_wdata   = cpu_wdata;
      state_d     = state_q;
      op_we_d     = op_we_q;
      cpu_rdata_d = cpu_rdata_q;
`ifdef VRAM_WBUF_EN
      pop         = 1'b0;
`endif

      case (state_q)
         S_RD: begin
            state_d = S_DONE;
            if (!op_we_q) begin
               cpu_rdata_d = mem_rdata;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = state_q;
      endcase

      // Slots 0 and 1 belong to video; the CPU only owns slots 2 and 3.
      if (cpu_slot) begin
         mem_addr = cpu_addr;
`ifdef VRAM_WBUF_EN
         // Draining posted writes first keeps reads ordered after them.
         if (!fifo_empty) begin
            pop       = 1'b1;
            mem_addr  = fifo_addr_q[rd_ptr_q];
            mem_wdata = fifo_data_q[rd_ptr_q];
            mem_we    = 1'b1;
         end else if ((state_q == S_IDLE) && cpu_req && !cpu_we) begin
            state_d = S_RD;
            op_we_d = 1'b0;
         end
`else
         if ((state_q == S_IDLE) && cpu_req) begin
            mem_we  = cpu_we;
            state_d = S_RD;
            op_we_d = cpu_we;
         end
`endif
      end
   end

   // CPU stall: reads (and unbuffered writes) release only in DONE.
   always_comb begin
`ifdef VRAM_WBUF_EN
      cpu_wait = (cpu_req & ~cpu_we & (state_q != S_DONE)) |
                 (cpu_req &  cpu_we & fifo_full);
`else
      cpu_wait = cpu_req & (state_q != S_DONE);
`endif
   end

   // Slot counter, FSM and output data registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ph_q        <= 2'd0;
         state_q     <= S_IDLE;
         op_we_q     <= 1'b0;
         vid_data_q  <= 8'h00;
         cpu_rdata_q <= 8'h00;
      end else begin
         ph_q        <= ph_d;
         state_q     <= state_d;
         op_we_q     <= op_we_d;
         vid_data_q  <= vid_data_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   assign vid_data  = vid_data_q;
   assign cpu_rdata = cpu_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vram_arbiter                                               |
// | Purpose  : Self-checking bench for vram_arbiter: directed slot/latency   |
// |            steps followed by random CPU traffic against a memory image.  |
// |            Works with or without VRAM_WBUF_EN defined.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_vram_arbiter;

`ifdef VRAM_WBUF_EN
   localparam bit WBUF = 1'b1;
`else
   localparam bit WBUF = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [13:0] vid_addr = 14'h0;
   logic [7:0]  vid_data;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [13:0] cpu_addr = 14'h0;
   logic [7:0]  cpu_wdata = 8'h0;
   logic [7:0]  cpu_rdata;
   logic        cpu_wait;
   logic [13:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   always #5 clock = ~clock;

   vram_arbiter #(.WBUF_DEPTH(4), .WBUF_AW(2)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .vid_addr  (vid_addr),
      .vid_data  (vid_data),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_wait  (cpu_wait),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Single-port synchronous RAM: data appears the cycle after its address.
   logic [7:0] ram [16384];
   always @(posedge clock) begin
      if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // Clocks elapsed since reset release; slot = cyc % 4.
   int cyc;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Video reference: the byte in RAM when slot 0 ends must be on vid_data in slot 2.
   logic [7:0] exp_vid;
   bit         vid_armed;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) vid_armed <= 1'b0;
      else if (cyc % 4 == 0) begin
         exp_vid   <= ram[vid_addr];
         vid_armed <= 1'b1;
      end
   end

   always @(negedge clock) begin
      if (reset_n && vid_armed && (cyc % 4 == 2)) check("vid_data", vid_data, exp_vid);
      if (!reset_n || (cyc % 4 < 2)) check("mem_we_video_slot", mem_we, 1'b0);
   end

   // Video address sweep over the CPU's random working range.
   bit sweep = 1'b0;
   initial forever begin
      @(posedge clock);
      #1;
      if (sweep) vid_addr = (vid_addr + 14'd1) & 14'h003F;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic align(input int p);
      int guard = 0;
      while ((cyc % 4 != p) && guard < 8) begin
         tick();
         guard++;
      end
   endtask

   task automatic cpu_write(input logic [13:0] a, input logic [7:0] d, output int waits);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; waits = 0;
      @(negedge clock);
      while (cpu_wait !== 1'b0 && waits < 100) begin
         waits++;
         @(negedge clock);
      end
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
   endtask

   task automatic cpu_read(input logic [13:0] a, output logic [7:0] d, output int waits,
                           input bit hold);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; waits = 0;
      @(negedge clock);
      while (cpu_wait !== 1'b0 && waits < 100) begin
         waits++;
         @(negedge clock);
      end
      d = cpu_rdata;
      if (hold) begin
         @(negedge clock);
         check("rd_wait_one_cycle", cpu_wait, 1'b1);
      end
      tick();
      cpu_req = 1'b0;
   endtask

   logic [7:0] shadow [64];
   int         exp_fill [7];
   int         w;
   logic [7:0] d;

   initial begin
`ifdef VRAM_WBUF_EN
      exp_fill = '{0, 0, 0, 0, 0, 0, 1};
`else
      exp_fill = '{4, 3, 3, 3, 3, 3, 3};
`endif
      for (int i = 0; i < 16384; i++) ram[i] = 8'($urandom);
      ram[14'h1ABC] = 8'h5A;
      vid_addr = 14'h1ABC;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_vid_data", vid_data, 8'h00);
      check("rst_cpu_rdata", cpu_rdata, 8'h00);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_cpu_wait", cpu_wait, 1'b0);

      // Video latency: two clocks, refreshed every four
      reset_n = 1'b1;
      tick();
      check("vid_lat_1clk", vid_data, 8'h00);
      tick();
      check("vid_lat_2clk", vid_data, 8'h5A);
      ram[14'h1ABC] = 8'hC3;
      repeat (4) tick();
      check("vid_refresh", vid_data, 8'hC3);

      // Single write: lands on the RAM in the next slot 2
      align(0);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2000; cpu_wdata = 8'h33;
      @(negedge clock);
      check("wr_wait_first", cpu_wait, WBUF ? 1'b0 : 1'b1);
      tick();
`ifdef VRAM_WBUF_EN
      cpu_req = 1'b0; cpu_we = 1'b0;
`endif
      @(negedge clock);
      @(negedge clock);
      check("wr_mem_we", mem_we, 1'b1);
      check("wr_mem_addr", mem_addr, 14'h2000);
      check("wr_mem_wdata", mem_wdata, 8'h33);
`ifndef VRAM_WBUF_EN
      @(negedge clock);
      check("wr_wait_rd", cpu_wait, 1'b1);
      @(negedge clock);
      check("wr_wait_done", cpu_wait, 1'b0);
      tick();
      cpu_req = 1'b0; cpu_we = 1'b0;
`endif
      repeat (4) tick();
      check("wr_ram", ram[14'h2000], 8'h33);

      // Best-case write and read started in a CPU slot
      align(2);
      cpu_write(14'h0010, 8'h77, w);
      check("wr_best_waits", w, WBUF ? 0 : 2);
      repeat (4) tick();
      check("wr_best_ram", ram[14'h0010], 8'h77);
      align(2);
      cpu_read(14'h0010, d, w, 1'b0);
      check("rd_best_waits", w, 2);
      check("rd_best_data", d, 8'h77);

      // Back-to-back writes: fill, full stall, pointer wrap
      align(0);
      for (int i = 0; i < 7; i++) begin
         cpu_write(14'h3000 + 14'(i), 8'h10 + 8'(i), w);
         check("fill_waits", w, exp_fill[i]);
      end
      repeat (8) tick();
      for (int i = 0; i < 7; i++) check("fill_ram", ram[14'h3000 + 14'(i)], 8'h10 + 8'(i));

      // Read right after a write to the same address
      align(0);
      cpu_write(14'h0100, 8'hA5, w);
      cpu_read(14'h0100, d, w, 1'b1);
      check("raw_data", d, 8'hA5);
      check("raw_waits", w, WBUF ? 4 : 3);
      repeat (4) tick();

      // Reset in the middle of activity
`ifdef VRAM_WBUF_EN
      for (int i = 0; i < 5; i++) ram[14'h3F00 + 14'(i)] = 8'h00;
      align(0);
      for (int i = 0; i < 5; i++) begin
         cpu_write(14'h3F00 + 14'(i), 8'hE0 + 8'(i), w);
         check("rst_fill_waits", w, 0);
      end
      tick();
      check("rst_pre_mem_we", mem_we, 1'b1);
      check("rst_pre_mem_addr", mem_addr, 14'h3F02);
`else
      align(2);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
      tick();
`endif
      reset_n = 1'b0;
      #1;
      check("rst_mem_we_now", mem_we, 1'b0);
      cpu_req = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst2_cpu_rdata", cpu_rdata, 8'h00);
      check("rst2_vid_data", vid_data, 8'h00);
      reset_n = 1'b1;
      repeat (8) tick();
`ifdef VRAM_WBUF_EN
      check("rst_kept0", ram[14'h3F00], 8'hE0);
      check("rst_kept1", ram[14'h3F01], 8'hE1);
      for (int i = 2; i < 5; i++) check("rst_lost", ram[14'h3F00 + 14'(i)], 8'h00);
`endif
      align(2);
      cpu_read(14'h0010, d, w, 1'b0);
      check("post_rst_waits", w, 2);
      check("post_rst_data", d, 8'h77);

      // Random CPU traffic against a memory image while video sweeps
      repeat (8) tick();
      for (int i = 0; i < 64; i++) shadow[i] = ram[i];
      vid_addr = 14'h0;
      sweep = 1'b1;
      for (int n = 0; n < 150; n++) begin
         int         gap;
         logic [5:0] a;
         logic [7:0] v;
         gap = $urandom_range(0, 3);
         repeat (gap) tick();
         a = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 99) < 55) begin
            v = 8'($urandom);
            cpu_write({8'h00, a}, v, w);
            check("rnd_wr_bounded", (w < 100) ? 1 : 0, 1);
            shadow[a] = v;
         end else begin
            cpu_read({8'h00, a}, d, w, 1'b0);
            check("rnd_rd_bounded", (w < 100) ? 1 : 0, 1);
            check("rnd_rd_data", d, shadow[a]);
         end
      end
      sweep = 1'b0;
      repeat (12) tick();
      for (int i = 0; i < 64; i++) check("rnd_ram_image", ram[i], shadow[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
